// File: rtl/i2s_tx_sequencer.sv
// i2s_tx_sequencer
// Derives MCLK/SCLK/LRCK from the system clock and serialises one stereo
// sample pair per 64-bit I2S frame (32-bit slots, one-bit data delay).
// A single-entry holding register decouples the sample producer from frame
// timing; a frame that starts with the holding register empty sends zeros
// and pulses underrun.
// Optional build macro: I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_cnt output.
module i2s_tx_sequencer #(
    parameter int DATA_W     = 24,
    parameter int MCLK_HALF  = 4,
    parameter int SCLK_RATIO = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              tx_mclk,
    output logic              tx_sclk,
    output logic              tx_lrck,
    output logic              tx_sdata,
    output logic              busy,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    output logic              underrun
);

    localparam int SPER = 2 * MCLK_HALF * SCLK_RATIO;
    localparam int SW   = (SPER > 1) ? $clog2(SPER) : 1;
    localparam int MW   = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(SPER - 1);
    localparam logic [SW-1:0] S_MID  = SW'(SPER / 2 - 1);
    localparam logic [MW-1:0] M_LAST = MW'(MCLK_HALF - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [MW-1:0] mcnt;
    logic [SW-1:0] scnt;
    logic          sfall;
    logic          shalf;

    logic [5:0]    bit_cnt;
    logic          frame_end;

    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              hold_full;
    logic              handshake;

    logic [31:0]   pad_l;
    logic [31:0]   pad_r;
    logic [31:0]   slot_l;
    logic [31:0]   slot_r;

    logic [5:0]    bit_inc;
    logic [4:0]    slot_n;
    logic [4:0]    bit_idx;
    logic [31:0]   src;
    logic          load;
    logic          sclk_nxt;
    logic          lrck_nxt;
    logic          sdata_nxt;
    logic [5:0]    cnt_nxt;
    logic          busy_nxt;
    logic          underrun_nxt;

    assign sfall     = (scnt == S_LAST);
    assign shalf     = (scnt == S_MID);
    assign frame_end = (bit_cnt == 6'd63);
    assign hold_full = ~s_ready;
    assign handshake = s_valid & s_ready;

    // Samples are left-justified into a 32-bit slot so bit 31 is always the MSB
    assign pad_l = 32'(hold_l) << (32 - DATA_W);
    assign pad_r = 32'(hold_r) << (32 - DATA_W);

    // Free-running dividers: MCLK toggles every MCLK_HALF clocks, scnt spans one SCLK period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt    <= '0;
            scnt    <= '0;
            tx_mclk <= 1'b0;
        end else begin
            if (mcnt == M_LAST) begin
                mcnt    <= '0;
                tx_mclk <= ~tx_mclk;
            end else begin
                mcnt <= mcnt + 1'b1;
            end
            if (scnt == S_LAST) begin
                scnt <= '0;
            end else begin
                scnt <= scnt + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start on any SCLK falling tick while enabled; stop only at a frame boundary
    always_comb begin
        state_nxt = state;
        if (sfall) begin
            case (state)
                IDLE:    if (enable) state_nxt = RUN;
                RUN:     if (frame_end && !enable) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the pin registers; the n=0 bit of a slot replays bit 0 of the previous slot
    always_comb begin
        bit_inc      = bit_cnt + 6'd1;
        slot_n       = bit_inc[4:0];
        bit_idx      = 5'd0 - slot_n;
        src          = bit_inc[5] ? slot_r : slot_l;
        if (slot_n == 5'd0) begin
            src = bit_inc[5] ? slot_l : slot_r;
        end
        load         = sfall && (state_nxt == RUN) && ((state == IDLE) || frame_end);
        sclk_nxt     = tx_sclk;
        lrck_nxt     = tx_lrck;
        sdata_nxt    = tx_sdata;
        cnt_nxt      = bit_cnt;
        busy_nxt     = (state_nxt == RUN);
        underrun_nxt = load && !hold_full;

        if (state_nxt == IDLE) begin
            sclk_nxt  = 1'b0;
            lrck_nxt  = 1'b0;
            sdata_nxt = 1'b0;
            cnt_nxt   = 6'd0;
        end else if (sfall) begin
            sclk_nxt = 1'b0;
            if (state == IDLE) begin
                lrck_nxt  = 1'b0;
                sdata_nxt = 1'b0;
                cnt_nxt   = 6'd0;
            end else begin
                lrck_nxt  = bit_inc[5];
                sdata_nxt = src[bit_idx];
                cnt_nxt   = bit_inc;
            end
        end else if (shalf) begin
            sclk_nxt = 1'b1;
        end
    end

    // Pin registers, frame bit counter and the per-frame slot words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_sclk  <= 1'b0;
            tx_lrck  <= 1'b0;
            tx_sdata <= 1'b0;
            bit_cnt  <= 6'd0;
            busy     <= 1'b0;
            underrun <= 1'b0;
            slot_l   <= '0;
            slot_r   <= '0;
        end else begin
            tx_sclk  <= sclk_nxt;
            tx_lrck  <= lrck_nxt;
            tx_sdata <= sdata_nxt;
            bit_cnt  <= cnt_nxt;
            busy     <= busy_nxt;
            underrun <= underrun_nxt;
            if (load) begin
                slot_l <= hold_full ? pad_l : 32'd0;
                slot_r <= hold_full ? pad_r : 32'd0;
            end
        end
    end

    // Holding register: a handshake fills it, a frame boundary drains it; a pair
    // captured on an underrunning boundary stays for the following frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_ready <= 1'b1;
            hold_l  <= '0;
            hold_r  <= '0;
        end else begin
            if (handshake) begin
                s_ready <= 1'b0;
                hold_l  <= s_left;
                hold_r  <= s_right;
            end else if (load && hold_full) begin
                s_ready <= 1'b1;
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating tally of underrun pulses, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= 16'd0;
        end else if (underrun_nxt && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// tb_i2s_tx_sequencer
// Scoreboarded bench for i2s_tx_sequencer with default parameters. A reference
// model derives clock/frame timing from the cycle count since reset release and
// queues the stereo pair each frame should carry; a monitor deserialises the
// I2S pins and compares against that queue.
// Honors the I2S_TX_UNDERRUN_CNT_EN build macro.
module tb_i2s_tx_sequencer;

    localparam int DW    = 24;
    localparam int FRAME = 2048;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          enable  = 1'b0;
    logic [DW-1:0] s_left  = '0;
    logic [DW-1:0] s_right = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          tx_mclk;
    logic          tx_sclk;
    logic          tx_lrck;
    logic          tx_sdata;
    logic          busy;
    logic          underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } frame_t;

    frame_t exp_q[$];

    int            k       = 0;
    bit            m_run   = 1'b0;
    int            m_k0    = 0;
    bit            m_full  = 1'b0;
    bit            m_under = 1'b0;
    int            m_ucnt  = 0;
    logic [DW-1:0] m_hl    = '0;
    logic [DW-1:0] m_hr    = '0;

    i2s_tx_sequencer #(
        .DATA_W    (DW),
        .MCLK_HALF (4),
        .SCLK_RATIO(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .s_left      (s_left),
        .s_right     (s_right),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .tx_mclk     (tx_mclk),
        .tx_sclk     (tx_sclk),
        .tx_lrck     (tx_lrck),
        .tx_sdata    (tx_sdata),
        .busy        (busy),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .underrun    (underrun)
    );

    // 100 MHz system clock
    initial begin
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s k=%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_mclk"}, 32'(tx_mclk), 32'd0);
        checkOutput({tag, "_sclk"}, 32'(tx_sclk), 32'd0);
        checkOutput({tag, "_lrck"}, 32'(tx_lrck), 32'd0);
        checkOutput({tag, "_sdata"}, 32'(tx_sdata), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
        checkOutput({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                                 input logic en);
        @(negedge clk);
        s_valid = v;
        s_left  = l;
        s_right = r;
        enable  = en;
    endtask

    // Reference model: SCLK falls every 32 clocks after release, frames last 2048 clocks,
    // frames carry accepted pairs in order or zeros when nothing was waiting
    initial begin
        bit hs;
        bit boundary;
        frame_t f;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                k       = 0;
                m_run   = 1'b0;
                m_full  = 1'b0;
                m_under = 1'b0;
                m_ucnt  = 0;
                exp_q.delete();
            end else begin
                k++;
                m_under  = 1'b0;
                boundary = 1'b0;
                hs       = s_valid && !m_full;
                if (k % 32 == 0) begin
                    if (!m_run) begin
                        if (enable) begin
                            m_run    = 1'b1;
                            m_k0     = k;
                            boundary = 1'b1;
                        end
                    end else if ((k - m_k0) % FRAME == 0) begin
                        if (enable) boundary = 1'b1;
                        else m_run = 1'b0;
                    end
                end
                if (boundary) begin
                    if (m_full) begin
                        f.l    = m_hl;
                        f.r    = m_hr;
                        m_full = 1'b0;
                    end else begin
                        f.l     = '0;
                        f.r     = '0;
                        m_under = 1'b1;
                        if (m_ucnt < 65535) m_ucnt++;
                    end
                    exp_q.push_back(f);
                end
                if (hs) begin
                    m_full = 1'b1;
                    m_hl   = s_left;
                    m_hr   = s_right;
                end
            end
        end
    end

    // Monitor: per-cycle pin timing against the model, plus I2S deserialisation into the scoreboard
    initial begin
        bit            prev_sclk = 1'b0;
        bit            prev_lr   = 1'b1;
        int            n         = 0;
        logic [DW-1:0] word      = '0;
        logic [DW-1:0] left_word = '0;
        frame_t        f;
        forever begin
            @(negedge clk);
            checkOutput("mclk", 32'(tx_mclk), 32'((k / 4) % 2));
            checkOutput("sclk", 32'(tx_sclk), 32'(m_run && (k % 32 >= 16)));
            checkOutput("lrck", 32'(tx_lrck), m_run ? 32'(((k - m_k0) / 1024) % 2) : 32'd0);
            checkOutput("busy", 32'(busy), 32'(m_run));
            checkOutput("underrun", 32'(underrun), 32'(m_under));
            checkOutput("s_ready", 32'(s_ready), 32'(!m_full));
`ifdef I2S_TX_UNDERRUN_CNT_EN
            checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
            if (reset || !m_run) begin
                prev_sclk = 1'b0;
                prev_lr   = 1'b1;
                n         = 0;
                word      = '0;
                checkOutput("sdata_idle", 32'(tx_sdata), 32'd0);
            end else begin
                if (tx_sclk && !prev_sclk) begin
                    if (tx_lrck != prev_lr) n = 0;
                    else n++;
                    prev_lr = tx_lrck;
                    if (n >= 1 && n <= DW) begin
                        word = {word[DW-2:0], tx_sdata};
                    end else begin
                        checkOutput("sdata_pad", 32'(tx_sdata), 32'd0);
                    end
                    if (n == DW) begin
                        if (!tx_lrck) begin
                            left_word = word;
                        end else begin
                            checkOutput("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                            if (exp_q.size() > 0) begin
                                f = exp_q.pop_front();
                                checkOutput("left_word", 32'(left_word), 32'(f.l));
                                checkOutput("right_word", 32'(word), 32'(f.r));
                            end
                        end
                        word = '0;
                    end
                end
                prev_sclk = tx_sclk;
            end
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        bit   found;
        logic a;
        logic b;
        $display("[TB] start");

        repeat (5) @(negedge clk);
        checkReset("reset_held");
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        checkReset("after_release");

        // Preload a known pair while idle, then run one data frame and three underrun frames
        applyStimulus(1'b1, 24'h800001, 24'h7FFFFE, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        repeat (4 * FRAME + 64) @(negedge clk);

        // Handshake arriving exactly on a frame boundary with the holding register empty
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (m_run && !m_full && ((k + 1 - m_k0) % FRAME == 0)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("boundary_found", 32'(found), 32'd1);
        s_valid = 1'b1;
        s_left  = 24'h123456;
        s_right = 24'hABCDEF;
        @(negedge clk);
        s_valid = 1'b0;
        if (found) begin
            checkOutput("boundary_underrun", 32'(underrun), 32'd1);
            checkOutput("boundary_capture", 32'(s_ready), 32'd0);
        end
        repeat (2 * FRAME) @(negedge clk);

        // Drop enable in the middle of the right slot; the frame completes then idles
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (m_run && ((k - m_k0) % FRAME == 1500)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("mid_right_found", 32'(found), 32'd1);
        enable = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (!m_run) break;
        end
        repeat (200) @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        a = tx_mclk;
        repeat (4) @(negedge clk);
        b = tx_mclk;
        checkOutput("mclk_idle_toggle", 32'(a ^ b), 32'd1);

        // Reset in the middle of the left slot with a pair waiting in the holding register
        enable = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (m_run && ((k - m_k0) % FRAME == 100)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("mid_left_found", 32'(found), 32'd1);
        s_valid = 1'b1;
        s_left  = 24'h0F0F0F;
        s_right = 24'hF0F0F0;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (50) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 checkReset("mid_frame_reset");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_run) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("post_reset_start", 32'(found), 32'd1);
        checkOutput("post_reset_underrun", 32'(underrun), 32'd1);

        // Randomized producer with occasional enable changes
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 4999) == 0) enable = ~enable;
            applyStimulus(($urandom_range(0, 1499) == 0), DW'($urandom), DW'($urandom), enable);
        end

        // Wind down and make sure every queued frame was seen on the pins
        applyStimulus(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 2 * FRAME + 64; i++) begin
            @(negedge clk);
            if (!m_run) break;
        end
        repeat (100) @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
